rsa_word_port: RTL and testbench

//  Core-side endpoint of the 64-bit word-serial operand/result interface into ModExp.
//  - Inbound: captures streamed M/E/N/R/T words into internal operand banks.
//  - Core side: gives the exponentiation core registered random-access reads of those banks
//    and accepts result words from the core.
//  - Outbound: streams the result back, LSW first, to the wide-operand top that reassembles the cypher.

---
 rtl/rsa_word_port_if.sv | 51 +++++
 rtl/rsa_word_port.sv | 143 ++++++++++++++
 tb/tb_rsa_word_port.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_word_port_if.sv
// rsa_word_port_if: operand load, core bank access and
// result streaming signals of the ModExp word port.
interface rsa_word_port_if #(
  parameter int DATA_WIDTH = 64,
  parameter int AW = 6
);
  logic                  start_in;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_m_word;
  logic [DATA_WIDTH-1:0] in_e_word;
  logic [DATA_WIDTH-1:0] in_n_word;
  logic [DATA_WIDTH-1:0] in_r_word;
  logic [DATA_WIDTH-1:0] in_t_word;
  logic                  loaded;
  logic                  busy;
  logic [2:0]            rd_sel;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  res_we;
  logic [AW-1:0]         res_addr;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_send;
  logic                  out_valid;
  logic [AW-1:0]         out_idx;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output start_in, in_valid,
    output in_m_word, in_e_word, in_n_word,
    output in_r_word, in_t_word,
    output rd_sel, rd_addr,
    output res_we, res_addr, res_data,
    output res_send,
    input  loaded, busy, rd_data,
    input  out_valid, out_idx,
    input  out_data, out_last
  );

  modport slave (
    input  start_in, in_valid,
    input  in_m_word, in_e_word, in_n_word,
    input  in_r_word, in_t_word,
    input  rd_sel, rd_addr,
    input  res_we, res_addr, res_data,
    input  res_send,
    output loaded, busy, rd_data,
    output out_valid, out_idx,
    output out_data, out_last
  );
endinterface

// File: rtl/rsa_word_port.sv
// rsa_word_port: captures streamed M/E/N/R/T operand words,
// serves core bank reads and streams the result back LSW first.
module rsa_word_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NWORDS = 64,
  parameter int AW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  rsa_word_port_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, LOAD, READY, SEND
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_in_cnt;
  logic [AW-1:0] r_out_cnt;

  logic [DATA_WIDTH-1:0] r_m   [NWORDS];
  logic [DATA_WIDTH-1:0] r_e   [NWORDS];
  logic [DATA_WIDTH-1:0] r_n   [NWORDS];
  logic [DATA_WIDTH-1:0] r_r   [NWORDS];
  logic [DATA_WIDTH-1:0] r_t   [NWORDS];
  logic [DATA_WIDTH-1:0] r_res [NWORDS];

  logic                  r_loaded;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_out_valid;
  logic [AW-1:0]         r_out_idx;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;

  logic                  w_bank_we;
  logic                  w_in_last;
  logic                  w_send;
  logic                  w_out_last;
  logic                  w_res_we;
  logic                  w_enter_load;
  logic                  w_enter_send;
  logic [DATA_WIDTH-1:0] w_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // start_in has priority over res_send
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, READY: begin
        if (bus.start_in)      w_next = LOAD;
        else if (bus.res_send) w_next = SEND;
      end
      LOAD: if (w_bank_we && w_in_last) w_next = READY;
      SEND: if (w_out_last) w_next = READY;
    endcase
  end

  always_comb begin
    w_bank_we    = (r_state == LOAD) && bus.in_valid;
    w_in_last    = (r_in_cnt == LAST);
    w_send       = (r_state == SEND);
    w_out_last   = (r_out_cnt == LAST);
    w_res_we     = bus.res_we && !w_send;
    w_enter_load = (w_next == LOAD) && (r_state != LOAD);
    w_enter_send = (w_next == SEND) && (r_state != SEND);
    w_rd         = '0;
    unique case (1'b1)
      bus.rd_sel == 3'd0: w_rd = r_m[bus.rd_addr];
      bus.rd_sel == 3'd1: w_rd = r_e[bus.rd_addr];
      bus.rd_sel == 3'd2: w_rd = r_n[bus.rd_addr];
      bus.rd_sel == 3'd3: w_rd = r_r[bus.rd_addr];
      bus.rd_sel == 3'd4: w_rd = r_t[bus.rd_addr];
      default:            w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_enter_load)
        r_in_cnt <= '0;
      else if (w_bank_we && !w_in_last)
        r_in_cnt <= r_in_cnt + 1'b1;
      if (w_enter_send)
        r_out_cnt <= '0;
      else if (w_send && !w_out_last)
        r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // operand and result storage is never reset
  always_ff @(posedge clk) begin
    if (w_bank_we) begin
      r_m[r_in_cnt] <= bus.in_m_word;
      r_e[r_in_cnt] <= bus.in_e_word;
      r_n[r_in_cnt] <= bus.in_n_word;
      r_r[r_in_cnt] <= bus.in_r_word;
      r_t[r_in_cnt] <= bus.in_t_word;
    end
    if (w_res_we)
      r_res[bus.res_addr] <= bus.res_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_loaded    <= w_bank_we && w_in_last;
      r_busy      <= (w_next == LOAD) || (w_next == SEND);
      r_rd_data   <= w_rd;
      r_out_valid <= w_send;
      r_out_last  <= w_send && w_out_last;
      if (w_send) begin
        r_out_idx  <= r_out_cnt;
        r_out_data <= r_res[r_out_cnt];
      end
    end
  end

  assign bus.loaded    = r_loaded;
  assign bus.busy      = r_busy;
  assign bus.rd_data   = r_rd_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_rsa_word_port.sv
// tb_rsa_word_port: scoreboard bench for operand load,
// core reads, result streaming and reset abort.
module tb_rsa_word_port;
  localparam int DW = 64;
  localparam int NW = 64;
  localparam int AW = 6;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } out_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rsa_word_port_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  rsa_word_port #(
    .DATA_WIDTH(DW),
    .NWORDS(NW),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int loaded_cnt = 0;
  int loaded_cyc = 0;
  int ov_cnt = 0;

  out_t          out_q [$];
  logic [DW-1:0] rd_q  [$];
  logic [DW-1:0] mdl   [5][NW];
  logic [DW-1:0] res_m [NW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    out_t e;
    #1;
    if (bus.loaded === 1'b1) begin
      loaded_cnt++;
      loaded_cyc = cyc;
    end
    if (bus.out_valid === 1'b1) begin
      ov_cnt++;
      if (out_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        e = out_q.pop_front();
        chk($sformatf("out_idx[%0d]", e.idx), bus.out_idx, e.idx);
        chk($sformatf("out_data[%0d]", e.idx), bus.out_data, e.data);
        chk($sformatf("out_last[%0d]", e.idx), bus.out_last, e.last);
        chk($sformatf("out_cyc[%0d]", e.idx), cyc, e.cyc);
      end
    end
  end

  function automatic logic [DW-1:0] pat(int v, int sel, int k);
    int x;
    x = sel * 'h100 + k + ((sel == 0) ? 0 : v * 'h10000);
    return DW'(x);
  endfunction

  task automatic set_words(int v, int k);
    bus.in_m_word = pat(v, 0, k);
    bus.in_e_word = pat(v, 1, k);
    bus.in_n_word = pat(v, 2, k);
    bus.in_r_word = pat(v, 3, k);
    bus.in_t_word = pat(v, 4, k);
  endtask

  task automatic junk_words();
    bus.in_m_word = '1;
    bus.in_e_word = '1;
    bus.in_n_word = '1;
    bus.in_r_word = '1;
    bus.in_t_word = '1;
  endtask

  task automatic do_load(int v, int stall_at, int stall_len,
                         bit with_send, output int dur);
    int s;
    int lw;
    loaded_cnt = 0;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.res_send = with_send;
    s = cyc;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.res_send = 1'b0;
    chk("busy_load", bus.busy, 1);
    for (int k = 0; k < NW; k++) begin
      set_words(v, k);
      bus.in_valid = 1'b1;
      bus.res_send = with_send && (k == 5);
      for (int j = 0; j < 5; j++) mdl[j][k] = pat(v, j, k);
      lw = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.res_send = 1'b0;
      if (k == stall_at)
        for (int j = 0; j < stall_len; j++) begin
          junk_words();
          @(negedge clk);
        end
    end
    repeat (2) @(negedge clk);
    chk("loaded_count", loaded_cnt, 1);
    chk("loaded_cyc", loaded_cyc, lw + 1);
    chk("busy_ready", bus.busy, 0);
    dur = loaded_cyc - s;
  endtask

  task automatic rd(int sel, int addr);
    logic [DW-1:0] exp;
    exp = (sel < 5) ? mdl[sel][addr] : '0;
    @(negedge clk);
    bus.rd_sel = 3'(sel);
    bus.rd_addr = AW'(addr);
    rd_q.push_back(exp);
    @(posedge clk);
    #1;
    chk($sformatf("rd[%0d][%0d]", sel, addr),
        bus.rd_data, rd_q.pop_front());
  endtask

  task automatic wr_res(int a, logic [DW-1:0] d, bit upd);
    @(negedge clk);
    bus.res_we = 1'b1;
    bus.res_addr = AW'(a);
    bus.res_data = d;
    if (upd) res_m[a] = d;
    @(negedge clk);
    bus.res_we = 1'b0;
  endtask

  task automatic do_send();
    out_t e;
    @(negedge clk);
    bus.res_send = 1'b1;
    for (int k = 0; k < NW; k++) begin
      e.idx = AW'(k);
      e.data = res_m[k];
      e.last = (k == NW - 1);
      e.cyc = cyc + 2 + k;
      out_q.push_back(e);
    end
    @(negedge clk);
    bus.res_send = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (out_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_q.size(), 0);
    out_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d1, d2, d4, ov0, hit;
    bus.start_in = 1'b0;
    bus.in_valid = 1'b0;
    junk_words();
    bus.rd_sel = '0;
    bus.rd_addr = '0;
    bus.res_we = 1'b0;
    bus.res_addr = '0;
    bus.res_data = '0;
    bus.res_send = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_loaded", bus.loaded, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    reset_n = 1'b1;

    do_load(0, -1, 0, 1'b0, d1);
    chk("load_dur", d1, NW + 1);
    rd(2, 5);
    chk("n5_const", bus.rd_data, 64'h205);
    rd(0, 63);
    rd(4, 0);
    rd(3, 31);
    for (int s = 5; s < 8; s++) rd(s, 7);

    @(negedge clk);
    bus.in_valid = 1'b1;
    junk_words();
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    rd(0, 0);
    rd(1, 1);

    do_load(1, 10, 3, 1'b0, d2);
    chk("stall_delay", d2 - d1, 3);
    rd(0, 11);
    chk("m11_const", bus.rd_data, 64'd11);
    rd(1, 11);
    rd(0, 10);
    rd(0, 12);
    rd(4, 63);

    for (int i = 0; i < NW; i++) wr_res(i, ~DW'(i), 1'b1);
    ov0 = ov_cnt;
    do_send();
    drain("send_drain");
    chk("send_count", ov_cnt - ov0, NW);
    @(negedge clk);
    chk("post_valid", bus.out_valid, 0);
    chk("post_last", bus.out_last, 0);
    chk("post_idx_hold", bus.out_idx, NW - 1);
    chk("post_data_hold", bus.out_data, ~DW'(NW - 1));
    chk("post_busy", bus.busy, 0);

    ov0 = ov_cnt;
    do_load(2, -1, 0, 1'b1, d4);
    chk("both_load_dur", d4, NW + 1);
    chk("both_no_send", ov_cnt - ov0, 0);
    rd(3, 20);

    do_send();
    @(negedge clk);
    bus.res_we = 1'b1;
    bus.res_addr = AW'(40);
    bus.res_data = 64'hDEAD;
    @(negedge clk);
    bus.res_we = 1'b0;
    drain("send_we_drain");

    wr_res(40, 64'hDEAD, 1'b1);
    do_send();
    drain("send_ready_we_drain");

    do_send();
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (bus.out_valid === 1'b1 && bus.out_idx == AW'(20)) begin
        hit = 1;
        break;
      end
    end
    chk("idx20_seen", hit, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    out_q.delete();
    ov0 = ov_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_no_resume", ov_cnt - ov0, 0);
    chk("abort_idle_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
